// File: rtl/reg_writeback_unit.sv
// Register-file write front end: merges single-cycle ALU results with in-order
// load returns onto one write port and tracks pending load destinations.
module reg_writeback_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 ld_issue,
  input  logic [ADDR_W-1:0]    ld_rd,
  output logic                 issue_ready,
  input  logic                 ld_valid,
  input  logic [DATA_W-1:0]    ld_data,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int NREG  = 2**ADDR_W;

  logic [PTR_W-1:0]  wr_ptr, fill_ptr, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt, rd_ptr_nxt;
  logic [PTR_W-1:0]  count, count_nxt;
  logic [ADDR_W-1:0] ent_rd   [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_filled;
  logic [1:0]        blk_cnt;

  logic [IDX_W-1:0]  wr_idx, fill_idx, head_idx;
  logic              issue_fire, fill_fire, fill_orphan;
  logic              head_ready, alu_acc, retire;
  logic              wsel_en_p0;
  logic [ADDR_W-1:0] wsel_addr_p0;
  logic [DATA_W-1:0] wsel_data_p0;
  logic [NREG-1:0]   busy_nxt;
  logic [ADDR_W-1:0] slot_rd;
  logic [IDX_W-1:0]  slot_off;

  assign wr_idx   = wr_ptr[IDX_W-1:0];
  assign fill_idx = fill_ptr[IDX_W-1:0];
  assign head_idx = rd_ptr[IDX_W-1:0];

  assign count       = wr_ptr - rd_ptr;
  assign issue_ready = (count != PTR_W'(DEPTH));
  assign alu_ready   = (blk_cnt < 2'd2);

  assign issue_fire  = ld_issue && issue_ready;
  // Fill only against loads issued in earlier cycles (pre-cycle wr_ptr).
  assign fill_fire   = ld_valid && (fill_ptr != wr_ptr);
  assign fill_orphan = ld_valid && (fill_ptr == wr_ptr);

  assign head_ready = (count != '0) && ent_filled[head_idx];
  assign alu_acc    = alu_valid && alu_ready;
  assign retire     = !alu_acc && head_ready;

  assign wr_ptr_nxt = wr_ptr + PTR_W'(issue_fire);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(retire);
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  // Write-port selection: ALU wins unless blocked by the anti-starvation counter.
  always_comb begin
    wsel_en_p0   = 1'b0;
    wsel_addr_p0 = '0;
    wsel_data_p0 = '0;
    if (alu_acc) begin
      wsel_en_p0   = 1'b1;
      wsel_addr_p0 = alu_rd;
      wsel_data_p0 = alu_data;
    end else if (retire) begin
      wsel_en_p0   = 1'b1;
      wsel_addr_p0 = ent_rd[head_idx];
      wsel_data_p0 = ent_data[head_idx];
    end
  end

  // Busy mask reflects queue contents after this cycle's issue and retire.
  always_comb begin
    busy_nxt = '0;
    slot_rd  = '0;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_rd  = (issue_fire && (IDX_W'(i) == wr_idx)) ? ld_rd : ent_rd[i];
      slot_off = IDX_W'(i) - rd_ptr_nxt[IDX_W-1:0];
      if (({1'b0, slot_off} < count_nxt) && (slot_rd != '0))
        busy_nxt[slot_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      fill_ptr   <= '0;
      rd_ptr     <= '0;
      ent_filled <= '0;
      blk_cnt    <= '0;
      err        <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (fill_fire) begin
        fill_ptr             <= fill_ptr + PTR_W'(1);
        ent_filled[fill_idx] <= 1'b1;
      end
      if (issue_fire)
        ent_filled[wr_idx] <= 1'b0;
      if (fill_orphan)
        err <= 1'b1;
      if (retire)
        blk_cnt <= '0;
      else if (head_ready && (blk_cnt != 2'd3))
        blk_cnt <= blk_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue_fire)
      ent_rd[wr_idx] <= ld_rd;
    if (fill_fire)
      ent_data[fill_idx] <= ld_data;
  end

  // ---- p0 -> register-file write port ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      busy_mask <= '0;
    end else begin
      rf_we     <= wsel_en_p0 && (wsel_addr_p0 != '0);
      busy_mask <= busy_nxt;
      if (wsel_en_p0) begin
        rf_waddr <= wsel_addr_p0;
        rf_wdata <= wsel_data_p0;
      end
    end
  end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
Write-side front end of the 32x32 register file. Merges single-cycle ALU results with variable-latency, in-order load returns into one register-file write port (rf_we/rf_waddr/rf_wdata). Tracks outstanding load destinations in busy_mask so decode can stall on RAW/WAW hazards. Sits between the execute/memory stages and the register file.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width (2**ADDR_W registers)
DEPTH, 4, max outstanding loads (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alu_valid  in  1  ALU result present this cycle
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
ld_issue  in  1  load issued to memory; reserves a queue slot
ld_rd  in  ADDR_W  load destination register
issue_ready  out  1  queue not full; ld_issue ignored when low
ld_valid  in  1  load data returning (oldest unfilled load, in order)
ld_data  in  DATA_W  returned load data
busy_mask  out  2**ADDR_W  bit n set = load to register n outstanding
rf_we  out  1  register-file write enable
rf_waddr  out  ADDR_W  register-file write address
rf_wdata  out  DATA_W  register-file write data
err  out  1  sticky protocol error

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, err=0, all queue pointers 0, block counter 0. Reset mid-operation discards all outstanding loads; later ld_valid with nothing outstanding sets err.
- Load queue: DEPTH entries {rd, data, filled}. Three pointers, each ADDR width log2(DEPTH)+1 with wrap bit: wr_ptr (issue), fill_ptr (data return), rd_ptr (retire). count = wr_ptr - rd_ptr.
- issue_ready = (count != DEPTH), from registered count only; a same-cycle retire does not free a slot for that cycle's issue.
- ld_issue && issue_ready: entry[wr_ptr] <= {ld_rd, x, 0}; wr_ptr++.
- ld_valid: if fill_ptr != wr_ptr (compared against pre-cycle wr_ptr), entry[fill_ptr].data <= ld_data, filled <= 1, fill_ptr++; else data dropped, err <= 1. Same-cycle ld_issue cannot be filled in that cycle.
- Head ready = count != 0 && entry[rd_ptr].filled.
- Arbitration per cycle, one write max:
  - alu_valid && alu_ready: write ALU result.
  - else if head ready: retire head, rd_ptr++.
  - else: no write.
- Anti-starvation: 2-bit block counter increments each cycle head ready but not retired; clears on retire. alu_ready = (block counter < 2). When low, the head retires that cycle and upstream holds alu_valid/alu_rd/alu_data stable.
- Write latency: registered outputs. rf_we/rf_waddr/rf_wdata valid the cycle after acceptance/retire, rf_we high for exactly one cycle per write.
- Register 0: writes with address 0 accepted and, for loads, retired normally, but rf_we stays 0. busy_mask[0] always 0.
- busy_mask: registered. Bit n = OR over in-queue entries (rd_ptr..wr_ptr-1) with rd==n, excluding n=0. Set the cycle after issue. Cleared in the same cycle rf_we asserts for the last pending load to n. Two loads to the same register keep the bit set until the second retires.
- No hazard checks on ALU writes. Decode must stall on busy_mask.
- err sticky until rst.

Test Plan:
- Reset then idle 5 cycles -> rf_we=0, busy_mask=0, issue_ready=1, alu_ready=1, err=0.
- ALU alu_rd=3, alu_data=0xDEADBEEF for 1 cycle -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF. Same with alu_rd=0 -> rf_we stays 0.
- ld_issue rd=5 and rd=5, then ld_valid 0x11, 0x22 -> busy_mask[5]=1 until the second write. Writes in order: (5,0x11) then (5,0x22). busy_mask[5] clears with the second rf_we.
- Issue 4 loads (rd=1..4) -> issue_ready=0. Extra ld_issue is ignored. Return all data -> 4 writes, rd 1..4 in order, issue_ready=1 again.
- Load head filled while alu_valid held high continuously -> after 2 blocked cycles alu_ready=0 for 1 cycle and the load writes. The held ALU result writes next, nothing lost.
- ld_valid with no outstanding load, and ld_valid after rst mid-flight -> err=1, no rf_we, busy_mask=0. err stays set until the next rst.
